// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and encodings for the load/store unit
//   state_t      : LSU control FSM states
//   F3_*         : RISC-V load/store funct3 codes
//   CAUSE_*      : lsu_fault_cause encodings
//   WL_*         : dcache_wordlen encodings shared with dcache
//   classify()   : fault classification of a request
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    localparam logic [1:0] WL_8  = 2'd0;
    localparam logic [1:0] WL_16 = 2'd1;
    localparam logic [1:0] WL_32 = 2'd2;

    // Illegal funct3 outranks misalignment; funct3[1:0] doubles as the size.
    function automatic logic [1:0] classify(input logic       store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (store) begin
            illegal = (funct3 > F3_W);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misaligned = ((funct3[1:0] == WL_16) && addr_lo[0]) ||
                     ((funct3[1:0] == WL_32) && (addr_lo != 2'b00));
        if (illegal) begin
            return CAUSE_ILLEGAL;
        end else if (misaligned) begin
            return CAUSE_MISALIGN;
        end
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - LSU to dcache request/response bus
//   master : LSU side (drives addr/datain/rdreq/wrreq/wordlen, receives dataout/valid)
//   slave  : dcache side
interface lsu_if #(
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32
);
    logic [ADDRBITS-1:0] dcache_addr;
    logic [DATABITS-1:0] dcache_datain;
    logic                dcache_rdreq;
    logic                dcache_wrreq;
    logic [1:0]          dcache_wordlen;
    logic [DATABITS-1:0] dcache_dataout;
    logic                dcache_valid;

    modport master (
        output dcache_addr, dcache_datain, dcache_rdreq, dcache_wrreq, dcache_wordlen,
        input  dcache_dataout, dcache_valid
    );

    modport slave (
        input  dcache_addr, dcache_datain, dcache_rdreq, dcache_wrreq, dcache_wordlen,
        output dcache_dataout, dcache_valid
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication and load extract/extend (combinational)
//   st_size/st_wdata -> st_data  : replicated store data for dcache_datain
//   ld_funct3/ld_offset/ld_word -> ld_data : extracted, extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);
    logic [31:0] shifted;

    // Replicate into every lane; the cache's byte enables pick the live one.
    always_comb begin
        st_data = st_wdata;
        case (st_size)
            WL_8:    st_data = {4{st_wdata[7:0]}};
            WL_16:   st_data = {2{st_wdata[15:0]}};
            default: st_data = st_wdata;
        endcase
    end

    always_comb begin
        shifted = ld_word >> {ld_offset, 3'b000};
        ld_data = shifted;
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: address generation, fault checks, dcache sequencing
//   clk, reset                     : clock, synchronous active-high reset
//   lsu_start/store/funct3/base/offset/wdata : request from execute stage
//   lsu_busy/done/rdata/fault/fault_cause    : status and load result (all registered)
//   dcache                         : lsu_if.master bus to the data cache
//   Optional watchdog in WAIT enabled by LSU_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDRBITS       = 32,
    parameter int DATABITS       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lsu_start,
    input  logic                lsu_store,
    input  logic [2:0]          lsu_funct3,
    input  logic [ADDRBITS-1:0] lsu_base,
    input  logic [ADDRBITS-1:0] lsu_offset,
    input  logic [DATABITS-1:0] lsu_wdata,
    output logic                lsu_busy,
    output logic                lsu_done,
    output logic [DATABITS-1:0] lsu_rdata,
    output logic                lsu_fault,
    output logic [1:0]          lsu_fault_cause,
    lsu_if.master               dcache
);
    state_t              state_q, state_d;
    logic [ADDRBITS-1:0] addr_q, addr_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                store_q, store_d;
    logic [DATABITS-1:0] datain_q, datain_d;
    logic [1:0]          wordlen_q, wordlen_d;
    logic                rdreq_q, rdreq_d;
    logic                wrreq_q, wrreq_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [1:0]          cause_q, cause_d;
    logic [DATABITS-1:0] rdata_q, rdata_d;

    logic [ADDRBITS-1:0] eff_addr;
    logic [1:0]          req_cause;
    logic [DATABITS-1:0] st_data;
    logic [DATABITS-1:0] ld_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign eff_addr  = lsu_base + lsu_offset;
    assign req_cause = classify(lsu_store, lsu_funct3, eff_addr[1:0]);

    // Store data is placed from the live request; loads extract from the
    // registered access descriptor against the returned word.
    lsu_align u_align (
        .st_size   (lsu_funct3[1:0]),
        .st_wdata  (lsu_wdata),
        .st_data   (st_data),
        .ld_funct3 (funct3_q),
        .ld_offset (addr_q[1:0]),
        .ld_word   (dcache.dcache_dataout),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        store_d   = store_q;
        datain_d  = datain_q;
        wordlen_d = wordlen_q;
        rdreq_d   = rdreq_q;
        wrreq_d   = wrreq_q;
        busy_d    = busy_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        cause_d   = CAUSE_NONE;
`ifdef LSU_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (lsu_start) begin
                    if (req_cause != CAUSE_NONE) begin
                        // Rejected without touching the cache; done next cycle.
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = req_cause;
                        rdata_d = '0;
                    end else begin
                        addr_d    = eff_addr;
                        funct3_d  = lsu_funct3;
                        store_d   = lsu_store;
                        datain_d  = st_data;
                        wordlen_d = lsu_funct3[1:0];
                        rdreq_d   = ~lsu_store;
                        wrreq_d   = lsu_store;
                        busy_d    = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // The cache registers the request here, so valid is not looked at.
                state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (dcache.dcache_valid) begin
                    rdreq_d = 1'b0;
                    wrreq_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = store_q ? '0 : ld_data;
                    state_d = S_IDLE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdreq_d = 1'b0;
                    wrreq_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    rdata_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                rdreq_d = 1'b0;
                wrreq_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            funct3_q  <= '0;
            store_q   <= 1'b0;
            datain_q  <= '0;
            wordlen_q <= '0;
            rdreq_q   <= 1'b0;
            wrreq_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            cause_q   <= CAUSE_NONE;
            rdata_q   <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            store_q   <= store_d;
            datain_q  <= datain_d;
            wordlen_q <= wordlen_d;
            rdreq_q   <= rdreq_d;
            wrreq_q   <= wrreq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
            rdata_q   <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign lsu_busy              = busy_q;
    assign lsu_done              = done_q;
    assign lsu_rdata             = rdata_q;
    assign lsu_fault             = fault_q;
    assign lsu_fault_cause       = cause_q;
    assign dcache.dcache_addr    = addr_q;
    assign dcache.dcache_datain  = datain_q;
    assign dcache.dcache_rdreq   = rdreq_q;
    assign dcache.dcache_wrreq   = wrreq_q;
    assign dcache.dcache_wordlen = wordlen_q;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;
    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_start;
    logic        lsu_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_base;
    logic [31:0] lsu_offset;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_fault;
    logic [1:0]  lsu_fault_cause;

    int checks = 0;
    int errors = 0;
    int seen_done;

    lsu_if #(.ADDRBITS(32), .DATABITS(32)) dc ();

    lsu #(.ADDRBITS(32), .DATABITS(32), .TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .lsu_start       (lsu_start),
        .lsu_store       (lsu_store),
        .lsu_funct3      (lsu_funct3),
        .lsu_base        (lsu_base),
        .lsu_offset      (lsu_offset),
        .lsu_wdata       (lsu_wdata),
        .lsu_busy        (lsu_busy),
        .lsu_done        (lsu_done),
        .lsu_rdata       (lsu_rdata),
        .lsu_fault       (lsu_fault),
        .lsu_fault_cause (lsu_fault_cause),
        .dcache          (dc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance across one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd);
        lsu_store  = st;
        lsu_funct3 = f3;
        lsu_base   = base;
        lsu_offset = off;
        lsu_wdata  = wd;
        lsu_start  = 1'b1;
    endtask

    // Legal access with the cache answering in the first WAIT cycle: done on the 3rd edge.
    task automatic fast_op(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] base, input logic [31:0] word,
                           input logic [31:0] exp_rdata);
        req(st, f3, base, 32'd0, 32'd0);
        dc.dcache_dataout = word;
        dc.dcache_valid   = 1'b1;
        tick();
        lsu_start = 1'b0;
        tick();
        chk({tag, "_nodone_wait"}, {31'd0, lsu_done}, 32'd0);
        tick();
        chk({tag, "_done"}, {31'd0, lsu_done}, 32'd1);
        chk({tag, "_rdata"}, lsu_rdata, exp_rdata);
        chk({tag, "_fault"}, {31'd0, lsu_fault}, 32'd0);
        dc.dcache_valid = 1'b0;
    endtask

    task automatic fault_op(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] base, input logic [1:0] exp_cause);
        req(st, f3, base, 32'd0, 32'hFFFF_FFFF);
        tick();
        lsu_start = 1'b0;
        chk({tag, "_done"}, {31'd0, lsu_done}, 32'd1);
        chk({tag, "_fault"}, {31'd0, lsu_fault}, 32'd1);
        chk({tag, "_cause"}, {30'd0, lsu_fault_cause}, {30'd0, exp_cause});
        chk({tag, "_rdata"}, lsu_rdata, 32'd0);
        chk({tag, "_noreq"}, {30'd0, dc.dcache_rdreq, dc.dcache_wrreq}, 32'd0);
        chk({tag, "_idle"}, {31'd0, lsu_busy}, 32'd0);
        tick();
        chk({tag, "_pulse"}, {31'd0, lsu_done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        lsu_start = 1'b0;
        lsu_store = 1'b0;
        lsu_funct3 = 3'b000;
        lsu_base = 32'd0;
        lsu_offset = 32'd0;
        lsu_wdata = 32'd0;
        dc.dcache_valid = 1'b0;
        dc.dcache_dataout = 32'd0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, lsu_busy}, 32'd0);
        chk("rst_done", {31'd0, lsu_done}, 32'd0);
        chk("rst_req", {30'd0, dc.dcache_rdreq, dc.dcache_wrreq}, 32'd0);
        chk("rst_addr", dc.dcache_addr, 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);

        // LW 0x100+4, valid in the second WAIT cycle -> done 4 edges after start.
        req(1'b0, 3'b010, 32'h100, 32'h4, 32'd0);
        tick();
        lsu_start = 1'b0;
        chk("lw_rdreq", {30'd0, dc.dcache_rdreq, dc.dcache_wrreq}, 32'd2);
        chk("lw_addr", dc.dcache_addr, 32'h104);
        chk("lw_wordlen", {30'd0, dc.dcache_wordlen}, 32'd2);
        chk("lw_busy", {31'd0, lsu_busy}, 32'd1);
        tick();
        chk("lw_wait_req", {31'd0, dc.dcache_rdreq}, 32'd1);
        tick();
        dc.dcache_dataout = 32'hDEAD_BEEF;
        dc.dcache_valid = 1'b1;
        chk("lw_nodone3", {31'd0, lsu_done}, 32'd0);
        tick();
        dc.dcache_valid = 1'b0;
        chk("lw_done4", {31'd0, lsu_done}, 32'd1);
        chk("lw_rdata", lsu_rdata, 32'hDEAD_BEEF);
        chk("lw_fault", {31'd0, lsu_fault}, 32'd0);
        chk("lw_reqdrop", {31'd0, dc.dcache_rdreq}, 32'd0);
        chk("lw_idle", {31'd0, lsu_busy}, 32'd0);
        tick();
        chk("lw_rdata_hold", lsu_rdata, 32'hDEAD_BEEF);

        // Load extraction.
        fast_op("lb", 1'b0, 3'b000, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
        fast_op("lbu", 1'b0, 3'b100, 32'h103, 32'h8011_2233, 32'h0000_0080);
        fast_op("lhu", 1'b0, 3'b101, 32'h102, 32'h8011_2233, 32'h0000_8011);
        fast_op("lh", 1'b0, 3'b001, 32'h102, 32'h8011_2233, 32'hFFFF_8011);
        fast_op("lh_lo", 1'b0, 3'b001, 32'h100, 32'h8011_2233, 32'h0000_2233);
        fast_op("lb_b1", 1'b0, 3'b000, 32'h101, 32'h8011_2233, 32'h0000_0022);

        // SH at 0x202: replicated halfword.
        req(1'b1, 3'b001, 32'h200, 32'h2, 32'h1234_ABCD);
        tick();
        lsu_start = 1'b0;
        chk("sh_req", {30'd0, dc.dcache_rdreq, dc.dcache_wrreq}, 32'd1);
        chk("sh_datain", dc.dcache_datain, 32'hABCD_ABCD);
        chk("sh_wordlen", {30'd0, dc.dcache_wordlen}, 32'd1);
        chk("sh_addr", dc.dcache_addr, 32'h202);
        tick();
        dc.dcache_valid = 1'b1;
        tick();
        dc.dcache_valid = 1'b0;
        chk("sh_done", {31'd0, lsu_done}, 32'd1);
        chk("sh_rdata", lsu_rdata, 32'd0);
        chk("sh_reqdrop", {31'd0, dc.dcache_wrreq}, 32'd0);

        // SB replicates the low byte; SW passes through.
        req(1'b1, 3'b000, 32'h201, 32'h0, 32'h5566_77CD);
        tick();
        lsu_start = 1'b0;
        chk("sb_datain", dc.dcache_datain, 32'hCDCD_CDCD);
        chk("sb_wordlen", {30'd0, dc.dcache_wordlen}, 32'd0);
        dc.dcache_valid = 1'b1;
        tick();
        tick();
        dc.dcache_valid = 1'b0;
        chk("sb_done", {31'd0, lsu_done}, 32'd1);
        req(1'b1, 3'b010, 32'h1FC, 32'h8, 32'h1234_5678);
        tick();
        lsu_start = 1'b0;
        chk("sw_datain", dc.dcache_datain, 32'h1234_5678);
        chk("sw_addr", dc.dcache_addr, 32'h204);
        dc.dcache_valid = 1'b1;
        tick();
        tick();
        dc.dcache_valid = 1'b0;
        chk("sw_done", {31'd0, lsu_done}, 32'd1);

        // Faults.
        fault_op("lw_mis", 1'b0, 3'b010, 32'h101, 2'b01);
        fault_op("lh_mis", 1'b0, 3'b101, 32'h103, 2'b01);
        fault_op("st_ill", 1'b1, 3'b011, 32'h100, 2'b11);
        fault_op("ld_ill_prio", 1'b0, 3'b110, 32'h101, 2'b11);
        fault_op("sw_ill4", 1'b1, 3'b100, 32'h100, 2'b11);

        // Base+offset wraps modulo 2^32.
        req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'd0);
        tick();
        lsu_start = 1'b0;
        chk("wrap_addr", dc.dcache_addr, 32'h4);
        dc.dcache_valid = 1'b1;
        tick();
        tick();
        dc.dcache_valid = 1'b0;
        chk("wrap_done", {31'd0, lsu_done}, 32'd1);

        // Back-to-back with start held and valid always high: done every 3 edges.
        req(1'b0, 3'b010, 32'h300, 32'h0, 32'd0);
        dc.dcache_dataout = 32'h1122_3344;
        dc.dcache_valid = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            chk($sformatf("b2b_done_t%0d", t), {31'd0, lsu_done}, (t % 3 == 0) ? 32'd1 : 32'd0);
        end
        lsu_start = 1'b0;
        dc.dcache_valid = 1'b0;
        chk("b2b_rdata", lsu_rdata, 32'h1122_3344);
        tick();

        // A start while busy is dropped.
        req(1'b0, 3'b010, 32'h104, 32'h0, 32'd0);
        tick();
        lsu_start = 1'b0;
        tick();
        req(1'b0, 3'b010, 32'h500, 32'h0, 32'd0);
        tick();
        lsu_start = 1'b0;
        chk("busy_addr_kept", dc.dcache_addr, 32'h104);
        dc.dcache_dataout = 32'hCAFE_F00D;
        dc.dcache_valid = 1'b1;
        tick();
        dc.dcache_valid = 1'b0;
        chk("busy_done", {31'd0, lsu_done}, 32'd1);
        chk("busy_rdata", lsu_rdata, 32'hCAFE_F00D);
        tick();
        chk("busy_noqueue", {30'd0, lsu_busy, dc.dcache_rdreq}, 32'd0);
        tick();
        chk("busy_noqueue2", {30'd0, lsu_busy, lsu_done}, 32'd0);

        // Reset asserted during WAIT.
        req(1'b0, 3'b010, 32'h100, 32'h0, 32'd0);
        tick();
        lsu_start = 1'b0;
        tick();
        reset = 1'b1;
        dc.dcache_valid = 1'b1;
        tick();
        reset = 1'b0;
        dc.dcache_valid = 1'b0;
        chk("rstw_req", {30'd0, dc.dcache_rdreq, dc.dcache_wrreq}, 32'd0);
        chk("rstw_busy_done", {30'd0, lsu_busy, lsu_done}, 32'd0);
        chk("rstw_rdata", lsu_rdata, 32'd0);
        chk("rstw_addr", dc.dcache_addr, 32'd0);
        seen_done = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (lsu_done) seen_done++;
        end
        chk("rstw_nodone", seen_done, 0);

`ifdef LSU_TIMEOUT_EN
        // Valid never arrives: four WAIT cycles then timeout fault.
        req(1'b0, 3'b010, 32'h100, 32'h0, 32'd0);
        tick();
        lsu_start = 1'b0;
        seen_done = 0;
        for (int t = 2; t <= 20 && seen_done == 0; t++) begin
            tick();
            if (lsu_done) begin
                seen_done = t;
            end
        end
        chk("to_edge", seen_done, 6);
        chk("to_fault", {31'd0, lsu_fault}, 32'd1);
        chk("to_cause", {30'd0, lsu_fault_cause}, 32'd2);
        chk("to_rdata", lsu_rdata, 32'd0);
        chk("to_req", {30'd0, dc.dcache_rdreq, dc.dcache_wrreq}, 32'd0);
`else
        // Without the watchdog the request is held indefinitely.
        req(1'b0, 3'b010, 32'h100, 32'h0, 32'd0);
        tick();
        lsu_start = 1'b0;
        seen_done = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (lsu_done) seen_done++;
        end
        chk("nowd_nodone", seen_done, 0);
        chk("nowd_req", {31'd0, dc.dcache_rdreq}, 32'd1);
        dc.dcache_dataout = 32'h0BAD_CAFE;
        dc.dcache_valid = 1'b1;
        tick();
        dc.dcache_valid = 1'b0;
        chk("nowd_done", {31'd0, lsu_done}, 32'd1);
        chk("nowd_fault", {31'd0, lsu_fault}, 32'd0);
        chk("nowd_rdata", lsu_rdata, 32'h0BAD_CAFE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
